// File: rtl/carrd_pkg.sv
// carrd_pkg: shared writeback types and default datapath widths for the Carrd coprocessor.
package carrd_pkg;
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_VREG = 2'd1,
        SEL_XREG = 2'd2
    } sel_dest_t;
    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 128;
    localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/carrd_wb_arbiter_if.sv
// carrd_wb_arbiter_if: per-source result handshakes plus the register-file write port.
interface carrd_wb_arbiter_if
    import carrd_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int LANES   = DEF_LANES,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int ADDR_W  = DEF_ADDR_W
);
    localparam int DW = LANES * LANE_W;
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*DW-1:0]     src_data;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC*2-1:0]      src_sel_dest;
    logic                      v_reg_wr_en;
    logic                      x_reg_wr_en;
    logic [ADDR_W-1:0]         reg_wr_addr;
    logic [DW-1:0]             reg_wr_data;
    logic [IW-1:0]             wb_src;
    modport slave (
        input  src_valid, src_data, src_addr, src_sel_dest,
        output src_ready, v_reg_wr_en, x_reg_wr_en, reg_wr_addr, reg_wr_data, wb_src
    );
    modport master (
        output src_valid, src_data, src_addr, src_sel_dest,
        input  src_ready, v_reg_wr_en, x_reg_wr_en, reg_wr_addr, reg_wr_data, wb_src
    );
endinterface

// File: rtl/carrd_rr_arb.sv
// carrd_rr_arb: one-hot arbiter, round-robin from an internal pointer or fixed lowest-index priority.
module carrd_rr_arb #(
    parameter int N       = 5,
    parameter int RR_MODE = 1,
    localparam int IW     = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    // Scan from the farthest offset down so the one nearest the pointer overwrites last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[IW'((int'(ptr) + k) % N)]) begin
                gnt = '0;
                gnt[IW'((int'(ptr) + k) % N)] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!nrst) ptr <= '0;
        else if (RR_MODE != 0 && |req) ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/carrd_wb_arbiter.sv
// carrd_wb_arbiter: buffers one result per execution unit and issues one registered RF write per cycle.
module carrd_wb_arbiter
    import carrd_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int LANES   = DEF_LANES,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RR_MODE = 1
) (
    input  logic                clk,
    input  logic                nrst,
    carrd_wb_arbiter_if.slave   bus,
    output logic                busy,
    output logic [7:0]          drop_cnt
);
    localparam int DW = LANES * LANE_W;
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0] full, gnt, cap, keep;
    logic [DW-1:0]      buf_data [NUM_SRC];
    logic [ADDR_W-1:0]  buf_addr [NUM_SRC];
    logic [1:0]         buf_sel  [NUM_SRC];
    logic [IW-1:0]      gnt_idx;
    logic [1:0]         g_sel;
    logic [15:0]        drop_sum;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_keep
        assign keep[i] = (bus.src_sel_dest[2*i +: 2] == SEL_VREG) || (bus.src_sel_dest[2*i +: 2] == SEL_XREG);
    end
    assign bus.src_ready = {NUM_SRC{nrst}} & (~full | gnt);
    assign cap = bus.src_valid & bus.src_ready;
    assign g_sel = buf_sel[gnt_idx];
    assign busy = |full | bus.v_reg_wr_en | bus.x_reg_wr_en;
    carrd_rr_arb #(.N(NUM_SRC), .RR_MODE(RR_MODE)) u_arb (
        .clk  (clk),
        .nrst (nrst),
        .req  (full),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );
    // Recapture wins over grant so a streaming source keeps its buffer occupied.
    always_ff @(posedge clk) begin
        if (!nrst) full <= '0;
        else full <= (cap & keep) | (full & ~gnt);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cap[k] && keep[k]) begin
                buf_data[k] <= bus.src_data[k*DW +: DW];
                buf_addr[k] <= bus.src_addr[k*ADDR_W +: ADDR_W];
                buf_sel[k]  <= bus.src_sel_dest[2*k +: 2];
            end
        end
    end
    always_comb begin
        drop_sum = {8'd0, drop_cnt};
        for (int k = 0; k < NUM_SRC; k++) drop_sum = drop_sum + 16'(cap[k] & ~keep[k]);
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            bus.v_reg_wr_en <= 1'b0;
            bus.x_reg_wr_en <= 1'b0;
            bus.reg_wr_addr <= '0;
            bus.reg_wr_data <= '0;
            bus.wb_src      <= '0;
            drop_cnt        <= '0;
        end else begin
            bus.v_reg_wr_en <= |gnt && g_sel == SEL_VREG;
            bus.x_reg_wr_en <= |gnt && g_sel == SEL_XREG;
            drop_cnt        <= drop_sum > 16'd255 ? 8'hFF : drop_sum[7:0];
            if (|gnt) begin
                bus.reg_wr_addr <= buf_addr[gnt_idx];
                bus.reg_wr_data <= g_sel == SEL_XREG ? DW'(buf_data[gnt_idx][31:0]) : buf_data[gnt_idx];
                bus.wb_src      <= gnt_idx;
            end
        end
    end
endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// tb_carrd_wb_arbiter: directed checks of capture, arbitration, drop counting and reset for both arbitration modes.
module tb_carrd_wb_arbiter;
    logic clk;
    logic nrst;
    logic busy_rr, busy_fp;
    logic [7:0] drop_rr, drop_fp;
    int n_chk = 0;
    int n_pass = 0;
    int tx, wr, strobes;
    logic [511:0] d1, d_sc;
    carrd_wb_arbiter_if #(.NUM_SRC(5), .LANES(4), .LANE_W(128), .ADDR_W(5)) bus_rr ();
    carrd_wb_arbiter_if #(.NUM_SRC(5), .LANES(4), .LANE_W(128), .ADDR_W(5)) bus_fp ();
    carrd_wb_arbiter #(.NUM_SRC(5), .LANES(4), .LANE_W(128), .ADDR_W(5), .RR_MODE(1)) u_rr (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (bus_rr.slave),
        .busy     (busy_rr),
        .drop_cnt (drop_rr)
    );
    carrd_wb_arbiter #(.NUM_SRC(5), .LANES(4), .LANE_W(128), .ADDR_W(5), .RR_MODE(0)) u_fp (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (bus_fp.slave),
        .busy     (busy_fp),
        .drop_cnt (drop_fp)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive_rr(input int i, input logic v, input logic [4:0] a, input logic [1:0] s, input logic [511:0] d);
        bus_rr.src_valid[i] = v;
        bus_rr.src_addr[i*5 +: 5] = a;
        bus_rr.src_sel_dest[i*2 +: 2] = s;
        bus_rr.src_data[i*512 +: 512] = d;
    endtask
    task automatic drive_fp(input int i, input logic v, input logic [4:0] a, input logic [1:0] s, input logic [511:0] d);
        bus_fp.src_valid[i] = v;
        bus_fp.src_addr[i*5 +: 5] = a;
        bus_fp.src_sel_dest[i*2 +: 2] = s;
        bus_fp.src_data[i*512 +: 512] = d;
    endtask
    initial begin
        nrst = 1'b0;
        bus_rr.src_valid = '0;
        bus_rr.src_data = '0;
        bus_rr.src_addr = '0;
        bus_rr.src_sel_dest = '0;
        bus_fp.src_valid = '0;
        bus_fp.src_data = '0;
        bus_fp.src_addr = '0;
        bus_fp.src_sel_dest = '0;
        tick;
        tick;
        check("rst_ready_rr", bus_rr.src_ready, 0);
        check("rst_ready_fp", bus_fp.src_ready, 0);
        check("rst_v", bus_rr.v_reg_wr_en, 0);
        check("rst_x", bus_rr.x_reg_wr_en, 0);
        check("rst_addr", bus_rr.reg_wr_addr, 0);
        check("rst_data", bus_rr.reg_wr_data, 0);
        check("rst_wb_src", bus_rr.wb_src, 0);
        check("rst_drop", drop_rr, 0);
        check("rst_busy", busy_rr, 0);
        nrst = 1'b1;
        tick;
        check("idle_ready", bus_rr.src_ready, 5'h1F);
        // single vector result from source 0
        d1 = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
        drive_rr(0, 1'b1, 5'd5, 2'd1, d1);
        tick;
        drive_rr(0, 1'b0, 5'd0, 2'd0, '0);
        check("vec_early_v", bus_rr.v_reg_wr_en, 0);
        check("vec_busy", busy_rr, 1);
        tick;
        check("vec_v", bus_rr.v_reg_wr_en, 1);
        check("vec_x", bus_rr.x_reg_wr_en, 0);
        check("vec_addr", bus_rr.reg_wr_addr, 5);
        check("vec_wb_src", bus_rr.wb_src, 0);
        check("vec_data", bus_rr.reg_wr_data, d1);
        tick;
        check("vec_pulse_end", bus_rr.v_reg_wr_en, 0);
        check("vec_addr_hold", bus_rr.reg_wr_addr, 5);
        // scalar result from source 4, upper bits must be cleared
        d_sc = {{480{1'b1}}, 32'hDEADBEEF};
        drive_rr(4, 1'b1, 5'd9, 2'd2, d_sc);
        tick;
        drive_rr(4, 1'b0, 5'd0, 2'd0, '0);
        tick;
        check("sc_x", bus_rr.x_reg_wr_en, 1);
        check("sc_v", bus_rr.v_reg_wr_en, 0);
        check("sc_data", bus_rr.reg_wr_data, 512'hDEADBEEF);
        check("sc_wb_src", bus_rr.wb_src, 4);
        check("sc_addr", bus_rr.reg_wr_addr, 9);
        tick;
        check("sc_pulse_end", bus_rr.x_reg_wr_en, 0);
        // all five sources complete together
        for (int i = 0; i < 5; i++) drive_rr(i, 1'b1, 5'(10 + i), 2'd1, {16{32'hA0 + 32'(i)}});
        tick;
        for (int i = 0; i < 5; i++) drive_rr(i, 1'b0, 5'd0, 2'd0, '0);
        check("sim_busy", busy_rr, 1);
        check("sim_no_v_yet", bus_rr.v_reg_wr_en, 0);
        for (int k = 0; k < 5; k++) begin
            tick;
            check("sim_v", bus_rr.v_reg_wr_en, 1);
            check("sim_wb_src", bus_rr.wb_src, k);
            check("sim_addr", bus_rr.reg_wr_addr, 10 + k);
            check("sim_data", bus_rr.reg_wr_data, {16{32'hA0 + 32'(k)}});
        end
        tick;
        check("sim_v_end", bus_rr.v_reg_wr_en, 0);
        check("sim_busy_end", busy_rr, 0);
        // sources 0 and 3 streaming under round-robin
        tx = 0;
        wr = 0;
        drive_rr(0, 1'b1, 5'd20, 2'd1, {16{32'h0000_0A0A}});
        drive_rr(3, 1'b1, 5'd23, 2'd1, {16{32'h0000_3B3B}});
        for (int c = 0; c < 10; c++) begin
            tx += int'(bus_rr.src_ready[0]) + int'(bus_rr.src_ready[3]);
            tick;
            if (bus_rr.v_reg_wr_en) begin
                check("rr_alt", bus_rr.wb_src, (wr % 2 == 1) ? 3 : 0);
                wr++;
            end
        end
        drive_rr(0, 1'b0, 5'd0, 2'd0, '0);
        drive_rr(3, 1'b0, 5'd0, 2'd0, '0);
        repeat (4) begin
            tick;
            if (bus_rr.v_reg_wr_en) begin
                check("rr_alt", bus_rr.wb_src, (wr % 2 == 1) ? 3 : 0);
                wr++;
            end
        end
        check("rr_tx", tx, 11);
        check("rr_wr", wr, 11);
        check("rr_busy_end", busy_rr, 0);
        // fixed priority: source 1 starves source 2
        drive_fp(1, 1'b1, 5'd1, 2'd1, {16{32'h1111_0001}});
        drive_fp(2, 1'b1, 5'd2, 2'd1, {16{32'h2222_0002}});
        for (int c = 0; c < 6; c++) begin
            tick;
            check("fp_ready2_low", bus_fp.src_ready[2], 0);
            if (c >= 1) check("fp_wb1", {bus_fp.v_reg_wr_en, 3'(bus_fp.wb_src)}, {1'b1, 3'd1});
        end
        drive_fp(1, 1'b0, 5'd0, 2'd0, '0);
        tick;
        check("fp_last1", {bus_fp.v_reg_wr_en, 3'(bus_fp.wb_src)}, {1'b1, 3'd1});
        check("fp_ready2_high", bus_fp.src_ready[2], 1);
        drive_fp(2, 1'b0, 5'd0, 2'd0, '0);
        tick;
        check("fp_wb2", {bus_fp.v_reg_wr_en, 3'(bus_fp.wb_src)}, {1'b1, 3'd2});
        check("fp_addr2", bus_fp.reg_wr_addr, 2);
        check("fp_data2", bus_fp.reg_wr_data, {16{32'h2222_0002}});
        tick;
        check("fp_v_end", bus_fp.v_reg_wr_en, 0);
        check("fp_busy_end", busy_fp, 0);
        // drops: two in one cycle, then saturation
        strobes = 0;
        drive_rr(0, 1'b1, 5'd3, 2'd0, '1);
        drive_rr(2, 1'b1, 5'd4, 2'd3, '1);
        tick;
        drive_rr(0, 1'b0, 5'd0, 2'd0, '0);
        drive_rr(2, 1'b0, 5'd0, 2'd0, '0);
        check("drop_two", drop_rr, 2);
        check("drop_not_buffered", busy_rr, 0);
        drive_rr(1, 1'b1, 5'd7, 2'd0, '1);
        repeat (300) begin
            tick;
            strobes += int'(bus_rr.v_reg_wr_en) + int'(bus_rr.x_reg_wr_en);
        end
        drive_rr(1, 1'b0, 5'd0, 2'd0, '0);
        tick;
        strobes += int'(bus_rr.v_reg_wr_en) + int'(bus_rr.x_reg_wr_en);
        check("drop_sat", drop_rr, 255);
        check("drop_no_strobe", strobes, 0);
        // reset with three results buffered
        for (int i = 1; i < 4; i++) drive_rr(i, 1'b1, 5'(i), 2'd1, {16{32'hCAFE_0000 + 32'(i)}});
        tick;
        for (int i = 1; i < 4; i++) drive_rr(i, 1'b0, 5'd0, 2'd0, '0);
        check("pre_rst_busy", busy_rr, 1);
        nrst = 1'b0;
        #1;
        check("rst_mid_ready", bus_rr.src_ready, 0);
        tick;
        nrst = 1'b1;
        check("rst_mid_v", bus_rr.v_reg_wr_en, 0);
        check("rst_mid_busy", busy_rr, 0);
        check("rst_mid_drop", drop_rr, 0);
        strobes = 0;
        repeat (5) begin
            tick;
            strobes += int'(bus_rr.v_reg_wr_en) + int'(bus_rr.x_reg_wr_en);
        end
        check("rst_mid_no_strobe", strobes, 0);
        check("rst_mid_idle", busy_rr, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
